// File: rtl/timer_bus_pkg.sv
// Shared constants and types for the timer bus initiator: register map,
// parameter defaults and the FSM state encoding.
package timer_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_EVT_W  = 16;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_COUNT   = 4'h4;
  localparam logic [3:0] ADDR_COMPARE = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RSP,
    SVC_RD,
    SVC_WR,
    SVC_CLR
  } state_t;

endpackage

// File: rtl/timer_bus_master.sv
// Timer bus initiator: turns single read/write commands into one-cycle bus
// strobes and, when enabled, services timer interrupts by advancing COMPARE.
module timer_bus_master
  import timer_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned EVT_W  = DEF_EVT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_wr_en,
  output logic              bus_rd_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_irq,
  input  logic              auto_en,
  input  logic [DATA_W-1:0] period,
  output logic [EVT_W-1:0]  evt_count,
  output logic              evt_pulse
);

  state_t              state, state_nxt;
  logic                irq_mask, irq_mask_nxt;
  logic                wr_en_nxt, rd_en_nxt, rsp_valid_nxt, evt_pulse_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, rdata_nxt;
  logic [EVT_W-1:0]    evt_count_nxt;
  logic                svc_req;

  // irq_mask hides the stale bus_irq seen in the first IDLE cycle after a clear
  assign svc_req   = auto_en && bus_irq && !irq_mask;
  assign cmd_ready = (state == IDLE) && !svc_req;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_wr_en <= 1'b0;
      bus_rd_en <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      evt_pulse <= 1'b0;
      evt_count <= '0;
      irq_mask  <= 1'b0;
    end else begin
      bus_wr_en <= wr_en_nxt;
      bus_rd_en <= rd_en_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rdata_nxt;
      evt_pulse <= evt_pulse_nxt;
      evt_count <= evt_count_nxt;
      irq_mask  <= irq_mask_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_en_nxt     = 1'b0;
    rd_en_nxt     = 1'b0;
    addr_nxt      = bus_addr;
    wdata_nxt     = bus_wdata;
    rsp_valid_nxt = rsp_valid;
    rdata_nxt     = rsp_rdata;
    evt_pulse_nxt = 1'b0;
    evt_count_nxt = evt_count;
    irq_mask_nxt  = irq_mask;
    case (state)
      IDLE: begin
        irq_mask_nxt = 1'b0;
        if (svc_req) begin
          state_nxt = SVC_RD;
          rd_en_nxt = 1'b1;
          addr_nxt  = ADDR_W'(ADDR_COMPARE);
        end else if (cmd_valid) begin
          addr_nxt = cmd_addr;
          if (cmd_write) begin
            state_nxt = WR;
            wr_en_nxt = 1'b1;
            wdata_nxt = cmd_wdata;
          end else begin
            state_nxt = RD;
            rd_en_nxt = 1'b1;
          end
        end
      end
      WR: state_nxt = IDLE;
      RD: begin
        rdata_nxt     = bus_rdata;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      // captured COMPARE plus period goes straight into the write-data register
      SVC_RD: begin
        state_nxt = SVC_WR;
        wr_en_nxt = 1'b1;
        wdata_nxt = bus_rdata + period;
      end
      SVC_WR: begin
        state_nxt = SVC_CLR;
        wr_en_nxt = 1'b1;
        addr_nxt  = ADDR_W'(ADDR_STATUS);
        wdata_nxt = '0;
      end
      SVC_CLR: begin
        state_nxt     = IDLE;
        evt_pulse_nxt = 1'b1;
        evt_count_nxt = evt_count + EVT_W'(1);
        irq_mask_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_bus_master.sv
// Bench for timer_bus_master: a small timer peripheral model, directed command
// stimulus, and a scoreboard that checks every strobe, response and event.
module tb_timer_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        bus_wr_en, bus_rd_en;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_irq;
  logic        auto_en;
  logic [31:0] period;
  logic [3:0]  evt_count;
  logic        evt_pulse;

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [31:0] exp_rsp[$];
  logic [3:0]  exp_evt[$];
  logic [35:0] m_w;
  logic [3:0]  m_a;
  logic [31:0] m_d;
  logic [31:0] cmp_model;

  // timer peripheral model
  logic [31:0] p_ctrl, p_cnt, p_cmp;
  logic        p_sts;

  timer_bus_master #(.ADDR_W(4), .DATA_W(32), .EVT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_irq(bus_irq),
    .auto_en(auto_en), .period(period),
    .evt_count(evt_count), .evt_pulse(evt_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) begin
      p_ctrl <= '0; p_cnt <= '0; p_cmp <= '0; p_sts <= 1'b0; bus_irq <= 1'b0;
    end else begin
      if (p_ctrl[0]) p_cnt <= p_cnt + 32'd1;
      if (p_ctrl[0] && p_cnt == p_cmp) p_sts <= 1'b1;
      if (bus_wr_en) begin
        case (bus_addr)
          4'h0: p_ctrl <= bus_wdata;
          4'h4: p_cnt  <= bus_wdata;
          4'h8: p_cmp  <= bus_wdata;
          4'hC: p_sts  <= bus_wdata[0];
          default: ;
        endcase
      end
      bus_irq <= p_sts;
    end
  end

  always_comb begin
    case (bus_addr)
      4'h0:    bus_rdata = p_ctrl;
      4'h4:    bus_rdata = p_cnt;
      4'h8:    bus_rdata = p_cmp;
      4'hC:    bus_rdata = {31'd0, p_sts};
      default: bus_rdata = '0;
    endcase
  end

  // scoreboard monitor: pops an expectation whenever the DUT presents an event
  always @(negedge clk) begin
    if (bus_wr_en && bus_rd_en) begin
      n_cmp = n_cmp + 1; n_err = n_err + 1;
      $display("FAIL strobe_onehot: both wr_en and rd_en high");
    end
    if (bus_wr_en) begin
      n_cmp = n_cmp + 1;
      if (exp_wr.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL bus_write: unexpected addr=%0h data=%0h", bus_addr, bus_wdata);
      end else begin
        m_w = exp_wr.pop_front();
        if (m_w !== {bus_addr, bus_wdata}) begin
          n_err = n_err + 1;
          $display("FAIL bus_write: got %0h/%0h expected %0h/%0h",
                   bus_addr, bus_wdata, m_w[35:32], m_w[31:0]);
        end
      end
    end
    if (bus_rd_en) begin
      n_cmp = n_cmp + 1;
      if (exp_rd.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL bus_read: unexpected addr=%0h", bus_addr);
      end else begin
        m_a = exp_rd.pop_front();
        if (m_a !== bus_addr) begin
          n_err = n_err + 1;
          $display("FAIL bus_read: got addr %0h expected %0h", bus_addr, m_a);
        end
      end
    end
    if (rsp_valid && rsp_ready) begin
      n_cmp = n_cmp + 1;
      if (exp_rsp.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL rsp: unexpected rdata=%0h", rsp_rdata);
      end else begin
        m_d = exp_rsp.pop_front();
        if (m_d !== rsp_rdata) begin
          n_err = n_err + 1;
          $display("FAIL rsp: got %0h expected %0h", rsp_rdata, m_d);
        end
      end
    end
    if (evt_pulse) begin
      n_cmp = n_cmp + 1;
      if (exp_evt.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL evt_pulse: unexpected, evt_count=%0d", evt_count);
      end else begin
        m_a = exp_evt.pop_front();
        if (m_a !== evt_count) begin
          n_err = n_err + 1;
          $display("FAIL evt_count: got %0d expected %0d", evt_count, m_a);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // waits for acceptance of the presented command; returns at T+1 plus 1ns
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d);
    if (wr) exp_wr.push_back({a, d});
    else    exp_rd.push_back(a);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    wait_accept();
  endtask

  task automatic push_svc(input logic [31:0] p, input logic [3:0] evt);
    exp_rd.push_back(4'h8);
    exp_wr.push_back({4'h8, cmp_model + p});
    exp_wr.push_back({4'hC, 32'd0});
    exp_evt.push_back(evt);
    cmp_model = cmp_model + p;
  endtask

  task automatic wait_evt(input logic [3:0] t, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (evt_count == t) break;
      @(posedge clk); #1;
    end
    chk("evt_wait", 32'(evt_count), 32'(t));
  endtask

  initial begin
    logic [31:0] p;
    bit ok;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; auto_en = 1'b0; period = '0;
    cycles(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_strobes", 32'({bus_wr_en, bus_rd_en, rsp_valid, evt_pulse}), 32'd0);
    chk("rst_evt_count", 32'(evt_count), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'd0);
    reset_n = 1'b1;
    cycles(1);

    // plain write: strobe exactly in T+1
    send_cmd(1'b1, 4'h0, 32'd1);
    chk("wr_strobe_t1", 32'(bus_wr_en), 32'd1);
    chk("wr_ready_t1", 32'(cmd_ready), 32'd0);
    cycles(1);
    chk("wr_strobe_t2", 32'(bus_wr_en), 32'd0);
    chk("wr_ready_t2", 32'(cmd_ready), 32'd1);
    send_cmd(1'b1, 4'h0, 32'd0);
    send_cmd(1'b1, 4'hC, 32'd0);
    send_cmd(1'b1, 4'h8, 32'h64);

    // read with stalled response
    rsp_ready = 1'b0;
    exp_rsp.push_back(32'h64);
    send_cmd(1'b0, 4'h8, 32'd0);
    chk("rd_strobe_t1", 32'(bus_rd_en), 32'd1);
    cycles(1);
    chk("rsp_valid_t2", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rsp_hold_data", rsp_rdata, 32'h64);
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_ready", 32'(cmd_ready), 32'd0);
      cycles(1);
    end
    rsp_ready = 1'b1;
    cycles(2);

    // auto-service driven by the running timer
    send_cmd(1'b1, 4'h8, 32'd50);
    send_cmd(1'b1, 4'h4, 32'd0);
    auto_en = 1'b1; period = 32'd100;
    cmp_model = 32'd50;
    send_cmd(1'b1, 4'h0, 32'd1);
    push_svc(32'd100, 4'd1);
    push_svc(32'd100, 4'd2);
    wait_evt(4'd1, 200);
    cycles(20);
    chk("no_stale_service", 32'(evt_count), 32'd1);
    wait_evt(4'd2, 300);
    send_cmd(1'b1, 4'h0, 32'd0);
    cycles(4);

    // COMPARE wrap and evt_count wrap over 14 serviced interrupts
    send_cmd(1'b1, 4'h8, 32'hFFFF_FFF0);
    cmp_model = 32'hFFFF_FFF0;
    for (int i = 0; i < 14; i++) begin
      p = (i == 0) ? 32'h20 : ((i % 2) != 0 ? 32'd0 : 32'd5);
      period = p;
      send_cmd(1'b1, 4'hC, 32'd1);
      push_svc(p, 4'(3 + i));
      wait_evt(4'(3 + i), 40);
      cycles(3);
    end
    chk("evt_wrap", 32'(evt_count), 32'd0);

    // irq and cmd_valid in the same IDLE cycle: service first
    auto_en = 1'b0;
    send_cmd(1'b1, 4'h4, 32'h1234);
    send_cmd(1'b1, 4'hC, 32'd1);
    cycles(3);
    push_svc(32'd9, 4'd1);
    exp_rd.push_back(4'h4);
    exp_rsp.push_back(32'h1234);
    auto_en = 1'b1; period = 32'd9;
    cmd_write = 1'b0; cmd_addr = 4'h4; cmd_valid = 1'b1;
    #1;
    chk("svc_prio_ready", 32'(cmd_ready), 32'd0);
    wait_accept();
    wait_evt(4'd1, 20);
    cycles(4);

    // reset while the service is in SVC_WR
    period = 32'd3;
    send_cmd(1'b1, 4'hC, 32'd1);
    exp_rd.push_back(4'h8);
    exp_wr.push_back({4'h8, cmp_model + 32'd3});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus_wr_en && bus_addr == 4'h8) begin ok = 1'b1; break; end
    end
    chk("svc_wr_reached", 32'(ok), 32'd1);
    reset_n = 1'b0; auto_en = 1'b0;
    cycles(1);
    chk("rst_svc_strobes", 32'({bus_wr_en, bus_rd_en, rsp_valid, evt_pulse}), 32'd0);
    chk("rst_svc_evt", 32'(evt_count), 32'd0);
    chk("rst_svc_ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    cmp_model = 32'd0;
    cycles(2);

    // reset while a response is pending
    rsp_ready = 1'b0;
    send_cmd(1'b0, 4'h8, 32'd0);
    cycles(1);
    chk("rsp_pending", 32'(rsp_valid), 32'd1);
    reset_n = 1'b0;
    cycles(1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_strobes", 32'({bus_wr_en, bus_rd_en}), 32'd0);
    chk("rst_rsp_ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1; rsp_ready = 1'b1;
    cycles(1);
    exp_rsp.push_back(32'd0);
    send_cmd(1'b0, 4'h8, 32'd0);
    cycles(10);

    chk("left_wr", 32'(exp_wr.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);
    chk("left_rsp", 32'(exp_rsp.size()), 32'd0);
    chk("left_evt", 32'(exp_evt.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
